// File: rtl/serializer_param.sv
// Parametrised word-to-bit serializer with a one-entry holding register for gapless streaming.
// Optional even-parity trailer cycle when SER_PARITY_EN is defined.
module serializer_param #(
  parameter int DATA_W    = 16,
  parameter int MIN_LEN   = 3,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      arst_i,
  input  logic [DATA_W-1:0]         data_i,
  input  logic [$clog2(DATA_W)-1:0] data_mod_i,
  input  logic                      data_val_i,
  output logic                      ser_data_o,
  output logic                      ser_data_val_o,
  output logic                      ser_last_o,
  output logic                      busy_o
);

  localparam int            CW       = $clog2(DATA_W);
  localparam logic [CW:0]   FULL_LEN = (CW+1)'(DATA_W);
  localparam logic [CW:0]   ONE      = (CW+1)'(1);
  localparam logic [CW-1:0] MIN_CODE = CW'(MIN_LEN);

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   shift_reg, shift_next;
  logic [CW:0]         cnt_reg, cnt_next;
  logic [DATA_W-1:0]   hold_data_reg, hold_data_next;
  logic [CW:0]         hold_len_reg, hold_len_next;
  logic                hold_full_reg, hold_full_next;
  logic                ser_data_reg, ser_data_next;
  logic                ser_val_reg, ser_val_next;
  logic                ser_last_reg, ser_last_next;
`ifdef SER_PARITY_EN
  logic                par_reg, par_next;
`endif

  logic                legal;
  logic                accept;
  logic [CW:0]         in_len;
  logic                cur_bit;
  logic [DATA_W-1:0]   shifted;
  logic                load_in, load_hold, store_hold, word_end;

  // Bit to send is always taken from the leading end of the shifter.
  generate
    if (MSB_FIRST) begin : g_msb
      assign cur_bit = shift_reg[DATA_W-1];
      assign shifted = shift_reg << 1;
    end else begin : g_lsb
      assign cur_bit = shift_reg[0];
      assign shifted = shift_reg >> 1;
    end
  endgenerate

  assign legal  = (data_mod_i == '0) || (data_mod_i >= MIN_CODE);
  assign accept = data_val_i && !hold_full_reg && legal;
  assign in_len = (data_mod_i == '0) ? FULL_LEN : {1'b0, data_mod_i};

  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    cnt_next       = cnt_reg;
    hold_data_next = hold_data_reg;
    hold_len_next  = hold_len_reg;
    hold_full_next = hold_full_reg;
    ser_data_next  = 1'b0;
    ser_val_next   = 1'b0;
    ser_last_next  = 1'b0;
    load_in        = 1'b0;
    load_hold      = 1'b0;
    store_hold     = 1'b0;
    word_end       = 1'b0;
`ifdef SER_PARITY_EN
    par_next       = par_reg;
`endif
    case (state_reg)
      IDLE: load_in = accept;
      SHIFT: begin
        ser_val_next  = 1'b1;
        ser_data_next = cur_bit;
        shift_next    = shifted;
        cnt_next      = cnt_reg - ONE;
`ifdef SER_PARITY_EN
        par_next      = par_reg ^ cur_bit;
        if (cnt_reg == ONE) begin
          state_next = PARITY;
          store_hold = accept;
        end else begin
          store_hold = accept;
        end
`else
        if (cnt_reg == ONE) begin
          ser_last_next = 1'b1;
          word_end      = 1'b1;
        end else begin
          store_hold = accept;
        end
`endif
      end
`ifdef SER_PARITY_EN
      PARITY: begin
        ser_val_next  = 1'b1;
        ser_data_next = par_reg;
        ser_last_next = 1'b1;
        word_end      = 1'b1;
      end
`endif
      default: state_next = IDLE;
    endcase

    // A held word has priority; otherwise a fresh word bypasses the hold.
    if (word_end) begin
      if (hold_full_reg) begin
        load_hold = 1'b1;
      end else if (accept) begin
        load_in = 1'b1;
      end else begin
        state_next = IDLE;
      end
    end

    if (store_hold) begin
      hold_data_next = data_i;
      hold_len_next  = in_len;
      hold_full_next = 1'b1;
    end
    if (load_hold) begin
      shift_next     = hold_data_reg;
      cnt_next       = hold_len_reg;
      hold_full_next = 1'b0;
      state_next     = SHIFT;
`ifdef SER_PARITY_EN
      par_next       = 1'b0;
`endif
    end
    if (load_in) begin
      shift_next = data_i;
      cnt_next   = in_len;
      state_next = SHIFT;
`ifdef SER_PARITY_EN
      par_next   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      cnt_reg       <= '0;
      hold_data_reg <= '0;
      hold_len_reg  <= '0;
      hold_full_reg <= 1'b0;
      ser_data_reg  <= 1'b0;
      ser_val_reg   <= 1'b0;
      ser_last_reg  <= 1'b0;
`ifdef SER_PARITY_EN
      par_reg       <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      cnt_reg       <= cnt_next;
      hold_data_reg <= hold_data_next;
      hold_len_reg  <= hold_len_next;
      hold_full_reg <= hold_full_next;
      ser_data_reg  <= ser_data_next;
      ser_val_reg   <= ser_val_next;
      ser_last_reg  <= ser_last_next;
`ifdef SER_PARITY_EN
      par_reg       <= par_next;
`endif
    end
  end

  assign ser_data_o     = ser_data_reg;
  assign ser_data_val_o = ser_val_reg;
  assign ser_last_o     = ser_last_reg;
  assign busy_o         = hold_full_reg;

endmodule
